// File: rtl/kf76489_pkg.sv
// Shared codes, sequencer state encoding and command-byte formatting for the
// KF76489 write-bus initiator.
package kf76489_pkg;

  typedef enum logic [1:0] {
    CH_TONE1 = 2'd0,
    CH_TONE2 = 2'd1,
    CH_TONE3 = 2'd2,
    CH_NOISE = 2'd3
  } channel_e;

  typedef enum logic {
    KIND_FREQ  = 1'b0,
    KIND_ATTEN = 1'b1
  } kind_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } seq_state_e;

  localparam int unsigned PHASE_MAX = 255;

  function automatic logic [7:0] bit_reverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  // The chip bus numbers bits opposite to the datasheet byte.
  function automatic logic [7:0] latch_byte(input logic [1:0] ch, input logic kind,
                                            input logic [3:0] nibble);
    return bit_reverse8({1'b1, ch, kind, nibble});
  endfunction

  function automatic logic [7:0] data_byte(input logic [5:0] hi);
    return bit_reverse8({2'b00, hi});
  endfunction

  function automatic logic needs_data_byte(input logic [1:0] ch, input logic kind);
    return (kind == KIND_FREQ) && (ch != CH_NOISE);
  endfunction

endpackage

// File: rtl/kf76489_write_strobe.sv
// Single-byte bus timing engine: setup, READY-gated strobe, hold and recovery,
// with a start/done handshake so the next byte can follow without an idle cycle.
module kf76489_write_strobe
  import kf76489_pkg::*;
#(
  parameter int SETUP_CYCLES    = 1,
  parameter int WE_LOW_CYCLES   = 2,
  parameter int HOLD_CYCLES     = 1,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] start_byte,
  input  logic       chip_ready,
  output logic       done,
  output logic       idle,
  output logic       ce_n,
  output logic       we_n,
  output logic [7:0] d_out
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > PHASE_MAX) begin : g_bad_setup
    $error("SETUP_CYCLES must be 1..255");
  end
  if (WE_LOW_CYCLES < 1 || WE_LOW_CYCLES > PHASE_MAX) begin : g_bad_we_low
    $error("WE_LOW_CYCLES must be 1..255");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > PHASE_MAX) begin : g_bad_hold
    $error("HOLD_CYCLES must be 1..255");
  end
  if (RECOVERY_CYCLES < 1 || RECOVERY_CYCLES > PHASE_MAX) begin : g_bad_recovery
    $error("RECOVERY_CYCLES must be 1..255");
  end

  // Timer holds the number of cycles remaining in the phase after the current one.
  localparam logic [7:0] SETUP_LOAD    = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] WE_LOW_LOAD   = 8'(WE_LOW_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD     = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] RECOVERY_LOAD = 8'(RECOVERY_CYCLES - 1);

  seq_state_e state_reg;
  logic [7:0] timer_reg;

  assign done = (state_reg == ST_RECOVER) && (timer_reg == 8'd0);
  assign idle = (state_reg == ST_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      timer_reg <= 8'd0;
      ce_n      <= 1'b1;
      we_n      <= 1'b1;
      d_out     <= 8'h00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_SETUP;
            timer_reg <= SETUP_LOAD;
            ce_n      <= 1'b0;
            d_out     <= start_byte;
          end
        end
        ST_SETUP: begin
          if (timer_reg == 8'd0) begin
            state_reg <= ST_STROBE;
            timer_reg <= WE_LOW_LOAD;
            we_n      <= 1'b0;
          end else begin
            timer_reg <= timer_reg - 8'd1;
          end
        end
        ST_STROBE: begin
          // Minimum low time first; READY only matters once it has elapsed.
          if (timer_reg != 8'd0) begin
            timer_reg <= timer_reg - 8'd1;
          end else if (chip_ready) begin
            state_reg <= ST_HOLD;
            timer_reg <= HOLD_LOAD;
            we_n      <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (timer_reg == 8'd0) begin
            state_reg <= ST_RECOVER;
            timer_reg <= RECOVERY_LOAD;
            ce_n      <= 1'b1;
          end else begin
            timer_reg <= timer_reg - 8'd1;
          end
        end
        ST_RECOVER: begin
          if (timer_reg == 8'd0) begin
            if (start) begin
              state_reg <= ST_SETUP;
              timer_reg <= SETUP_LOAD;
              ce_n      <= 1'b0;
              d_out     <= start_byte;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            timer_reg <= timer_reg - 8'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          timer_reg <= 8'd0;
          ce_n      <= 1'b1;
          we_n      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/kf76489_write_sequencer.sv
// Request capture and one/two-byte command sequencing for the KF76489 write bus;
// bus timing is delegated to kf76489_write_strobe.
module kf76489_write_sequencer
  import kf76489_pkg::*;
#(
  parameter int SETUP_CYCLES    = 1,
  parameter int WE_LOW_CYCLES   = 2,
  parameter int HOLD_CYCLES     = 1,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_channel,
  input  logic       req_kind,
  input  logic [9:0] req_value,
  input  logic       READY,
  output logic       busy,
  output logic       CE_N,
  output logic       WE_N,
  output logic [7:0] D_OUT
);

  logic       accept;
  logic [3:0] req_nibble;
  logic       strobe_start;
  logic [7:0] strobe_byte;
  logic       strobe_done;
  logic       strobe_idle;
  logic       data_pending_reg;
  logic [7:0] data_byte_reg;

  assign req_ready = strobe_idle;
  assign busy      = !strobe_idle;
  assign accept    = req_valid && req_ready;

  // Noise control carries only three bits; the fourth nibble bit is forced low.
  assign req_nibble = (req_kind == KIND_FREQ && req_channel == CH_NOISE)
                      ? {1'b0, req_value[2:0]} : req_value[3:0];

  // The data byte launches straight out of the latch byte's recovery phase.
  assign strobe_start = accept || (strobe_done && data_pending_reg);
  assign strobe_byte  = accept ? latch_byte(req_channel, req_kind, req_nibble)
                               : data_byte_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_pending_reg <= 1'b0;
      data_byte_reg    <= 8'h00;
    end else if (accept) begin
      data_pending_reg <= needs_data_byte(req_channel, req_kind);
      data_byte_reg    <= data_byte(req_value[9:4]);
    end else if (strobe_done && data_pending_reg) begin
      data_pending_reg <= 1'b0;
    end
  end

  kf76489_write_strobe #(
    .SETUP_CYCLES   (SETUP_CYCLES),
    .WE_LOW_CYCLES  (WE_LOW_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .RECOVERY_CYCLES(RECOVERY_CYCLES)
  ) u_strobe (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (strobe_start),
    .start_byte(strobe_byte),
    .chip_ready(READY),
    .done      (strobe_done),
    .idle      (strobe_idle),
    .ce_n      (CE_N),
    .we_n      (WE_N),
    .d_out     (D_OUT)
  );

endmodule

// File: tb/tb_kf76489_write_sequencer.sv
// Randomised and directed bench for kf76489_write_sequencer: a bus monitor checks
// timing and bytes against a request-level model of the command encoding.
module tb_kf76489_write_sequencer;

  localparam int S = 1;
  localparam int W = 2;
  localparam int H = 1;
  localparam int R = 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_channel = 2'd0;
  logic       req_kind = 1'b0;
  logic [9:0] req_value = 10'd0;
  logic       READY = 1'b1;
  logic       busy;
  logic       CE_N;
  logic       WE_N;
  logic [7:0] D_OUT;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  bit mon_en = 1'b0;
  int last_we_len = 0;

  kf76489_write_sequencer #(
    .SETUP_CYCLES(S), .WE_LOW_CYCLES(W), .HOLD_CYCLES(H), .RECOVERY_CYCLES(R)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_channel(req_channel), .req_kind(req_kind), .req_value(req_value),
    .READY(READY), .busy(busy), .CE_N(CE_N), .WE_N(WE_N), .D_OUT(D_OUT)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Datasheet bit k of a command byte appears on bus bit 7-k.
  function automatic logic [7:0] model_latch(input int ch, input int kind, input int val);
    int nib;
    int d;
    nib = (kind == 0 && ch == 3) ? (val % 8) : (val % 16);
    d = 1 + ((ch / 2) % 2) * 2 + (ch % 2) * 4 + kind * 8;
    for (int i = 0; i < 4; i++) if (((nib >> i) & 1) == 1) d += (1 << (7 - i));
    return d[7:0];
  endfunction

  function automatic logic [7:0] model_data(input int val);
    int hi;
    int d;
    hi = (val / 16) % 64;
    d = 0;
    for (int i = 0; i < 6; i++) if (((hi >> i) & 1) == 1) d += (1 << (7 - i));
    return d[7:0];
  endfunction

  // Bus monitor: phase lengths, READY-gated strobe release, byte contents, CE_N gaps.
  bit prev_ce, prev_we, pend, strobed, seen_byte;
  int we_cnt, setup_cnt, hold_cnt, gap;
  always @(negedge clock) begin
    if (!mon_en || !reset_n) begin
      prev_ce = 1; prev_we = 1; pend = 0; strobed = 0; seen_byte = 0;
      we_cnt = 0; setup_cnt = 0; hold_cnt = 0; gap = 0;
    end else begin
      if (CE_N == 1'b0) begin
        if (prev_ce) begin
          if (seen_byte) check_val("recovery_gap", 32'(gap >= R), 1);
          seen_byte = 1; we_cnt = 0; setup_cnt = 0; hold_cnt = 0; strobed = 0; pend = 0;
        end
        gap = 0;
        if (WE_N == 1'b0) begin
          if (!prev_we) check_val("we_release_late", 32'(pend), 0);
          we_cnt++;
          pend = (we_cnt >= W) && READY;
        end else begin
          if (!prev_we) begin
            check_val("we_exit_cond", 32'(pend), 1);
            check_val("setup_len", setup_cnt, S);
            last_we_len = we_cnt;
            strobed = 1;
            obs_q.push_back(D_OUT);
            check_val("byte_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_val("d_out", D_OUT, exp_q.pop_front());
          end
          if (strobed) hold_cnt++; else setup_cnt++;
        end
      end else begin
        if (!prev_ce) begin
          check_val("hold_len", hold_cnt, H);
          check_val("we_high_at_ce_rise", WE_N, 1);
        end
        gap++;
      end
      prev_ce = CE_N;
      prev_we = WE_N;
    end
  end

  // Issue one request from a negedge; lat = cycles req_ready stays low after accept.
  task automatic do_req(input int ch, input int kind, input int val, input bit keep,
                        output int lat);
    int n;
    int busy_cnt;
    req_channel = 2'(ch);
    req_kind    = kind[0];
    req_value   = 10'(val);
    req_valid   = 1'b1;
    n = 0;
    while (!req_ready && n < 300) begin @(negedge clock); n++; end
    if (n >= 300) check_val("accept_timeout", n, 0);
    exp_q.push_back(model_latch(ch, kind, val));
    if (kind == 0 && ch != 3) exp_q.push_back(model_data(val));
    @(posedge clock);
    #1;
    if (!keep) req_valid = 1'b0;
    lat = 0;
    busy_cnt = 0;
    @(negedge clock);
    while (!req_ready && lat < 2000) begin
      lat++;
      busy_cnt += int'(busy);
      @(negedge clock);
    end
    if (lat >= 2000) check_val("ready_timeout", lat, 0);
    check_val("busy_len", busy_cnt, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n2;
    int ce_low;
    int ch, k, v, nb;
    bit rand_done;

    repeat (3) @(negedge clock);
    check_val("rst_ce_n", CE_N, 1);
    check_val("rst_we_n", WE_N, 1);
    check_val("rst_d_out", D_OUT, 0);
    check_val("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check_val("rst_req_ready", req_ready, 1);
    mon_en = 1'b1;
    @(negedge clock);

    // Tone1 frequency: latch then data byte, back-to-back.
    obs_q.delete();
    do_req(0, 0, 'h1AB, 0, lat);
    $display("tone1 freq 1AB: latency=%0d", lat);
    check_val("tone1_latency", lat, 10);
    check_val("tone1_we_len", last_we_len, 2);
    check_val("tone1_bytes", obs_q.size(), 2);
    if (obs_q.size() > 0) check_val("tone1_latch", obs_q.pop_front(), 8'hD1);
    if (obs_q.size() > 0) check_val("tone1_data", obs_q.pop_front(), 8'h58);

    // Tone2 attenuation: single byte.
    obs_q.delete();
    do_req(1, 1, 'h5, 0, lat);
    $display("tone2 atten 5: latency=%0d", lat);
    check_val("atten_latency", lat, 5);
    check_val("atten_bytes", obs_q.size(), 1);
    if (obs_q.size() > 0) check_val("atten_byte", obs_q.pop_front(), 8'hAD);

    // Noise control with junk in the upper value bits.
    obs_q.delete();
    do_req(3, 0, 'h3FD, 0, lat);
    $display("noise ctrl 3FD: latency=%0d", lat);
    check_val("noise_latency", lat, 5);
    check_val("noise_bytes", obs_q.size(), 1);
    if (obs_q.size() > 0) check_val("noise_byte", obs_q.pop_front(), 8'hA7);

    // READY low for the first part of the strobe stretches WE_N to 6 cycles.
    obs_q.delete();
    fork
      do_req(0, 1, 'h3, 0, lat);
      begin
        n2 = 0;
        do begin @(negedge clock); n2++; end while (WE_N && n2 < 50);
        #1 READY = 1'b0;
        repeat (5) @(posedge clock);
        #1 READY = 1'b1;
      end
    join
    $display("ready stretch: latency=%0d we_len=%0d", lat, last_we_len);
    check_val("stretch_latency", lat, 9);
    check_val("stretch_we_len", last_we_len, 6);

    // Three back-to-back frequency writes with req_valid held high.
    for (int i = 0; i < 3; i++) begin
      do_req(i, 0, 'h100 + i * 37, 1, lat);
      $display("b2b req %0d: latency=%0d", i, lat);
      check_val("b2b_latency", lat, 10);
    end
    req_valid = 1'b0;
    check_val("b2b_drain", exp_q.size(), 0);

    // Reset during the strobe of a frequency latch byte.
    @(negedge clock);
    mon_en = 1'b0;
    req_channel = 2'd0; req_kind = 1'b0; req_value = 10'h1AB; req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    n2 = 0;
    do begin @(negedge clock); n2++; end while (WE_N && n2 < 50);
    check_val("mid_reset_reached_strobe", WE_N, 0);
    #2 reset_n = 1'b0;
    #1;
    check_val("mid_reset_ce_n", CE_N, 1);
    check_val("mid_reset_we_n", WE_N, 1);
    check_val("mid_reset_d_out", D_OUT, 0);
    check_val("mid_reset_busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    ce_low = 0;
    repeat (12) begin @(negedge clock); ce_low += int'(!CE_N); end
    $display("mid-transfer reset: ce_low_after_release=%0d", ce_low);
    check_val("mid_reset_no_data_byte", ce_low, 0);
    check_val("mid_reset_req_ready", req_ready, 1);
    exp_q.delete();
    mon_en = 1'b1;
    @(negedge clock);

    // Randomised requests against random READY.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          ch = $urandom_range(0, 3);
          k  = $urandom_range(0, 1);
          v  = $urandom_range(0, 1023);
          do_req(ch, k, v, 1, lat);
          nb = (k == 0 && ch != 3) ? 2 : 1;
          $display("rand req %0d: ch=%0d kind=%0d value=%0h bytes=%0d latency=%0d",
                   i, ch, k, v, nb, lat);
          check_val("rand_min_latency", 32'(lat >= nb * (S + W + H + R)), 1);
          check_val("rand_drain", exp_q.size(), 0);
        end
        req_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clock);
          #1 READY = ($urandom_range(0, 3) != 0);
        end
        READY = 1'b1;
      end
    join

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
